seq_mult_7b: RTL and testbench
==============================

SEQ_MULT_7B -- requirements
Module: seq_mult_7b

Interface
REQ-001 SHALL have parameter OP_W, default 7, operand width in bits; product width is 2*OP_W (14 at default).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous, active-high reset.
REQ-004 SHALL have port start, input, 1, request to begin a multiply; sampled only in IDLE.
REQ-005 SHALL have port a, input, OP_W, multiplicand, captured on the accepted start cycle.
REQ-006 SHALL have port b, input, OP_W, multiplier, captured on the accepted start cycle.
REQ-007 SHALL have port prod, output, 2*OP_W, registered product, feeds the 14-bit binary-to-decimal converter.
REQ-008 SHALL have port busy, output, 1, high from the cycle after an accepted start through the done cycle inclusive.
REQ-009 SHALL have port done, output, 1, single-cycle pulse marking prod updated.
REQ-010 SHALL have port ovf, output, 1, saturation flag (see Configuration).

Function
REQ-011 SHALL implement FSM states IDLE, RUN, DONE.
REQ-012 IDLE with start=1 SHALL capture a and b, clear the accumulator and iteration counter, and go to RUN; IDLE with start=0 SHALL remain in IDLE.
REQ-013 RUN SHALL perform one shift-add step per cycle, LSB first: if the current multiplier bit is 1, add the shifted multiplicand into the 2*OP_W accumulator; no truncation.
REQ-014 RUN SHALL last exactly OP_W cycles, counted by an iteration counter of ceil(log2(OP_W+1)) bits, then go to DONE.
REQ-015 On entry to DONE, prod (and ovf) SHALL load the final result, done=1 for that one cycle, and the next state SHALL be IDLE.
REQ-016 Latency: start accepted at edge N SHALL give done=1 in cycle N+OP_W+1 (N+8 at default).
REQ-017 start while busy=1 SHALL be ignored and SHALL NOT corrupt operands or the accumulator.
REQ-018 start in the DONE cycle SHALL be ignored; the earliest next accept is the following IDLE cycle.
REQ-019 prod and ovf SHALL hold their values between completions and change only on a DONE load or reset.
REQ-020 The result SHALL be the exact unsigned product; a=0 or b=0 SHALL yield 0 with normal latency.

Reset
REQ-021 rst=1 SHALL immediately force state IDLE, prod=0, busy=0, done=0, ovf=0, accumulator, operands and counter=0, including mid-RUN (operation aborted, no done pulse).
REQ-022 After rst deasserts, the first start SHALL be accepted at the next rising edge.

Configuration
REQ-023 Macro MULT_SAT_EN: when defined, a final product above 9999 SHALL load prod=9999 and ovf=1 in DONE, and a product at or below 9999 SHALL load exactly with ovf=0.
REQ-024 When MULT_SAT_EN is not defined, prod SHALL carry the raw product (max 16129) and ovf SHALL be tied 0.

Structure
REQ-025 Shared package SHALL hold the FSM state encoding, OP_W default, and constant SAT_MAX=9999.
REQ-026 The design SHALL be a single module with no sub-module; the saturation compare is an inline conditional under MULT_SAT_EN.

Verification
REQ-027 a=12, b=11, start pulse -> busy high 8 cycles, done pulse at N+8, prod=132, ovf=0.
REQ-028 a=127, b=127 -> prod=16129, ovf=0 without MULT_SAT_EN; prod=9999, ovf=1 with it.
REQ-029 a=0, b=100 -> done at N+8, prod=0; then a=1, b=1 -> prod=1.
REQ-030 a=5, b=6 accepted, then start held high with a=9, b=9 through RUN and DONE -> prod=30; 9*9=81 accepted only in the following IDLE cycle.
REQ-031 rst pulsed at RUN cycle 4 of a=100, b=50 -> prod=0, busy=0, no done pulse; a new start afterwards gives the correct product.

Source files
------------

// File: rtl/seq_mult_7b_pkg.sv
// Shared constants for the sequential shift-add multiplier:
// FSM state encoding, default operand width and the saturation ceiling.
package seq_mult_7b_pkg;

    localparam int OP_W_DEF = 7;
    localparam int SAT_MAX  = 9999;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/seq_mult_7b.sv
// Sequential LSB-first shift-add unsigned multiplier, one partial product per cycle.
// Optional feature: define MULT_SAT_EN to clamp products above SAT_MAX and flag ovf.
module seq_mult_7b
    import seq_mult_7b_pkg::*;
#(
    parameter int OP_W = OP_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [OP_W-1:0]     a,
    input  logic [OP_W-1:0]     b,
    output logic [2*OP_W-1:0]   prod,
    output logic                busy,
    output logic                done,
    output logic                ovf
);

    localparam int P_W   = 2 * OP_W;
    localparam int CNT_W = $clog2(OP_W + 1);

    logic [1:0]       state_reg;
    logic [P_W-1:0]   mcand_reg;
    logic [OP_W-1:0]  mplier_reg;
    logic [P_W-1:0]   acc_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [P_W-1:0]   prod_reg;

    logic [P_W-1:0]   acc_next;
    logic [P_W-1:0]   result_next;
    logic             last_step;
    logic             sat_hit;

    // The multiplicand is pre-shifted each step, so the add always uses multiplier bit 0.
    assign acc_next  = acc_reg + (mplier_reg[0] ? mcand_reg : '0);
    assign last_step = (cnt_reg == CNT_W'(OP_W - 1));

`ifdef MULT_SAT_EN
    localparam logic [P_W-1:0] SAT_VAL = P_W'(SAT_MAX);
    logic ovf_reg;

    always_comb begin
        sat_hit     = (acc_next > SAT_VAL);
        result_next = sat_hit ? SAT_VAL : acc_next;
    end

    assign ovf = ovf_reg;
`else
    always_comb begin
        sat_hit     = 1'b0;
        result_next = acc_next;
    end

    assign ovf = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= ST_IDLE;
            mcand_reg  <= '0;
            mplier_reg <= '0;
            acc_reg    <= '0;
            cnt_reg    <= '0;
            prod_reg   <= '0;
`ifdef MULT_SAT_EN
            ovf_reg    <= 1'b0;
`endif
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        mcand_reg  <= P_W'(a);
                        mplier_reg <= b;
                        acc_reg    <= '0;
                        cnt_reg    <= '0;
                        state_reg  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    acc_reg    <= acc_next;
                    mcand_reg  <= mcand_reg << 1;
                    mplier_reg <= mplier_reg >> 1;
                    cnt_reg    <= cnt_reg + CNT_W'(1);
                    // Final step: the result register loads on the edge that enters DONE.
                    if (last_step) begin
                        prod_reg  <= result_next;
`ifdef MULT_SAT_EN
                        ovf_reg   <= sat_hit;
`endif
                        state_reg <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign prod = prod_reg;
    assign busy = (state_reg != ST_IDLE);
    assign done = (state_reg == ST_DONE);

endmodule

// File: tb/tb_seq_mult_7b.sv
// Scoreboard bench for seq_mult_7b: driver models acceptance and pushes expected
// products; an independent negedge monitor consumes them on each done pulse.
module tb_seq_mult_7b;

    localparam int OP_W = 7;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [OP_W-1:0]   a;
    logic [OP_W-1:0]   b;
    logic [2*OP_W-1:0] prod;
    logic              busy;
    logic              done;
    logic              ovf;

    seq_mult_7b #(.OP_W(OP_W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .prod  (prod),
        .busy  (busy),
        .done  (done),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        int p;
        int o;
    } exp_t;

    exp_t exp_q[$];
    int   rd_idx    = 0;
    int   flush_idx = 0;
    int   busy_left = 0;
    int   tests     = 0;
    int   fails     = 0;
    int   held_prod = 0;
    int   held_ovf  = 0;

    task automatic chk(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Reference: the unit is unavailable for OP_W+1 cycles after it accepts a request.
    task automatic step(input logic r, input logic s, input int av, input int bv);
        exp_t e;
        @(negedge clk);
        #1;
        rst   = r;
        start = s;
        a     = OP_W'(av);
        b     = OP_W'(bv);
        if (r) begin
            busy_left = 0;
            flush_idx = exp_q.size();
        end else if (busy_left > 0) begin
            busy_left--;
        end else if (s) begin
            e.p = av * bv;
            e.o = 0;
`ifdef MULT_SAT_EN
            if (e.p > 9999) begin
                e.p = 9999;
                e.o = 1;
            end
`endif
            exp_q.push_back(e);
            $display("[TB] issue a=%0d b=%0d expect prod=%0d ovf=%0d", av, bv, e.p, e.o);
            busy_left = OP_W + 1;
        end
    endtask

    always @(negedge clk) begin
        if (rst === 1'b1) begin
            held_prod = 0;
            held_ovf  = 0;
            rd_idx    = flush_idx;
        end
        chk("busy", int'(busy), int'(busy_left > 0));
        chk("done", int'(done), int'(busy_left == 1));
        if (done === 1'b1) begin
            if (rd_idx >= exp_q.size()) begin
                chk("sb_underflow", 1, 0);
            end else begin
                held_prod = exp_q[rd_idx].p;
                held_ovf  = exp_q[rd_idx].o;
                rd_idx++;
                $display("[TB] done prod=%0d ovf=%0d (expected %0d/%0d)", prod, ovf, held_prod, held_ovf);
            end
        end
        chk("prod", int'(prod), held_prod);
        chk("ovf", int'(ovf), held_ovf);
    end

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) @(negedge clk);

        // First start right as reset releases, then the directed corner cases.
        step(0, 1, 12, 11);
        repeat (10) step(0, 0, 0, 0);
        step(0, 1, 127, 127);
        repeat (10) step(0, 0, 0, 0);
        step(0, 1, 0, 100);
        repeat (9) step(0, 0, 0, 0);
        step(0, 1, 1, 1);
        repeat (9) step(0, 0, 0, 0);
        step(0, 1, 100, 0);
        repeat (9) step(0, 0, 0, 0);

        // start held through RUN and DONE with different operands.
        step(0, 1, 5, 6);
        repeat (9) step(0, 1, 9, 9);
        repeat (10) step(0, 0, 0, 0);

        // Abort mid-RUN, then a clean operation.
        step(0, 1, 100, 50);
        repeat (4) step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 1, 100, 50);
        repeat (10) step(0, 0, 0, 0);

        // Random traffic including starts while busy and occasional resets.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 79) == 0), ($urandom_range(0, 1) == 1),
                 int'($urandom_range(0, 127)), int'($urandom_range(0, 127)));
        end
        repeat (12) step(0, 0, 0, 0);

        @(negedge clk);
        #2;
        chk("drain", rd_idx, exp_q.size());
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
